// File: rtl/uartprobe_engine.sv
// ---------------------------------------------------------------------------
// uartprobe_engine
// Command engine for the UART probe. Decodes a byte-stream protocol coming
// from the UART wrapper, drives GPO, snapshots GPI and runs single-beat AXI
// read/write transactions, answering every command with a status/data reply.
//
// Ports
//   clk, aresetn                 clock, asynchronous active-low reset
//   rx_valid/rx_data/rx_ready    command byte stream in (from wrapper)
//   tx_valid/tx_data/tx_ready    response byte stream out (to wrapper)
//   gpo / gpi                    general purpose outputs / inputs (GW bits)
//   m_axi_ar* / m_axi_r*         AXI read address / read data channels
//   m_axi_aw* / m_axi_w*         AXI write address / write data channels
//   m_axi_b*                     AXI write response channel
//
// Protocol (multi-byte fields MSB first)
//   01 ping -> A5            02 GPI rd -> GPIO_BYTES    03 GPO rd -> GPIO_BYTES
//   04 GPO wr + payload -> 00 05 ADDR wr + 4 -> 00      06 ADDR rd -> 4 bytes
//   07 AXI rd -> {resp},data  08 AXI wr + data -> {resp} other -> E0
//   payload stall longer than RX_TIMEOUT cycles -> E1
// ---------------------------------------------------------------------------
module uartprobe_engine #(
   parameter int unsigned              GPIO_BYTES        = 4,
   parameter int unsigned              DATA_BYTES        = 1,
   parameter logic [8*GPIO_BYTES-1:0]  GPO_ON_RESET      = '0,
   parameter logic [31:0]              AXI_ADDR_ON_RESET = '0,
   parameter int unsigned              RX_TIMEOUT        = 1024
) (
   input  logic                     clk,
   input  logic                     aresetn,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   output logic                     rx_ready,
   output logic                     tx_valid,
   output logic [7:0]               tx_data,
   input  logic                     tx_ready,
   output logic [8*GPIO_BYTES-1:0]  gpo,
   input  logic [8*GPIO_BYTES-1:0]  gpi,
   output logic [31:0]              m_axi_araddr,
   output logic                     m_axi_arvalid,
   input  logic                     m_axi_arready,
   output logic [2:0]               m_axi_arsize,
   input  logic [8*DATA_BYTES-1:0]  m_axi_rdata,
   input  logic [1:0]               m_axi_rresp,
   input  logic                     m_axi_rvalid,
   output logic                     m_axi_rready,
   input  logic                     m_axi_rlast,
   output logic [31:0]              m_axi_awaddr,
   output logic                     m_axi_awvalid,
   input  logic                     m_axi_awready,
   output logic [2:0]               m_axi_awsize,
   output logic [8*DATA_BYTES-1:0]  m_axi_wdata,
   output logic [DATA_BYTES-1:0]    m_axi_wstrb,
   output logic                     m_axi_wlast,
   output logic                     m_axi_wvalid,
   input  logic                     m_axi_wready,
   input  logic [1:0]               m_axi_bresp,
   input  logic                     m_axi_bvalid,
   output logic                     m_axi_bready
);

   localparam int unsigned GW   = 8 * GPIO_BYTES;
   localparam int unsigned DW   = 8 * DATA_BYTES;
   localparam int unsigned B0   = (GPIO_BYTES > 4) ? GPIO_BYTES : 4;
   // longest reply: GPIO read, address read, or resp byte + AXI data
   localparam int unsigned TXB  = (B0 > DATA_BYTES + 1) ? B0 : DATA_BYTES + 1;
   // longest payload: GPO value, address, or AXI write data
   localparam int unsigned SHB  = (B0 > DATA_BYTES) ? B0 : DATA_BYTES;
   localparam int unsigned TXW  = 8 * TXB;
   localparam int unsigned SHW  = 8 * SHB;
   localparam int unsigned LW   = $clog2(TXB + 1);
   localparam int unsigned TW   = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_RX_PAY, S_AXI_AR, S_AXI_R, S_AXI_AWW, S_AXI_B, S_TX
   } state_t;

   state_t           state_q;
   logic [7:0]       op_q;
   logic [LW-1:0]    len_q;      // bytes still to receive (RX_PAY) or send (TX)
   logic [TW-1:0]    timer_q;
   logic [SHW-1:0]   pay_q;      // payload shadow, committed only when complete
   logic [SHW-1:0]   pay_d;
   logic [TXW-1:0]   tx_q;       // reply shift register, next byte in top lane
   logic [GW-1:0]    gpo_q;
   logic [31:0]      addr_q;
   logic [31:0]      ax_addr_q;
   logic [DW-1:0]    wdata_q;
   logic             rx_ready_q;
   logic             tx_valid_q;
   logic             arvalid_q;
   logic             rready_q;
   logic             awvalid_q;
   logic             wvalid_q;
   logic             bready_q;

   assign pay_d = {pay_q[SHW-9:0], rx_data};

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         len_q      <= '0;
         timer_q    <= '0;
         pay_q      <= '0;
         tx_q       <= '0;
         gpo_q      <= GPO_ON_RESET;
         addr_q     <= AXI_ADDR_ON_RESET;
         ax_addr_q  <= '0;
         wdata_q    <= '0;
         rx_ready_q <= 1'b0;
         tx_valid_q <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         bready_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               rx_ready_q <= 1'b1;
               if (rx_valid && rx_ready_q) begin
                  op_q    <= rx_data;
                  timer_q <= '0;
                  tx_q    <= '0;
                  case (rx_data)
                     8'h01: begin
                        tx_q[TXW-1 -: 8] <= 8'hA5;
                        len_q      <= LW'(1);
                        rx_ready_q <= 1'b0;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_TX;
                     end
                     8'h02: begin
                        // snapshot all GPI bytes at once so the reply is coherent
                        tx_q[TXW-1 -: GW] <= gpi;
                        len_q      <= LW'(GPIO_BYTES);
                        rx_ready_q <= 1'b0;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_TX;
                     end
                     8'h03: begin
                        tx_q[TXW-1 -: GW] <= gpo_q;
                        len_q      <= LW'(GPIO_BYTES);
                        rx_ready_q <= 1'b0;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_TX;
                     end
                     8'h06: begin
                        tx_q[TXW-1 -: 32] <= addr_q;
                        len_q      <= LW'(4);
                        rx_ready_q <= 1'b0;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_TX;
                     end
                     8'h04: begin
                        len_q   <= LW'(GPIO_BYTES);
                        state_q <= S_RX_PAY;
                     end
                     8'h05: begin
                        len_q   <= LW'(4);
                        state_q <= S_RX_PAY;
                     end
                     8'h08: begin
                        len_q   <= LW'(DATA_BYTES);
                        state_q <= S_RX_PAY;
                     end
                     8'h07: begin
                        ax_addr_q  <= addr_q;
                        arvalid_q  <= 1'b1;
                        rx_ready_q <= 1'b0;
                        state_q    <= S_AXI_AR;
                     end
                     default: begin
                        tx_q[TXW-1 -: 8] <= 8'hE0;
                        len_q      <= LW'(1);
                        rx_ready_q <= 1'b0;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_TX;
                     end
                  endcase
               end
            end

            S_RX_PAY: begin
               if (rx_valid && rx_ready_q) begin
                  pay_q   <= pay_d;
                  timer_q <= '0;
                  len_q   <= len_q - 1'b1;
                  if (len_q == LW'(1)) begin
                     rx_ready_q <= 1'b0;
                     tx_q       <= '0;
                     len_q      <= LW'(1);
                     case (op_q)
                        8'h04: begin
                           gpo_q      <= pay_d[GW-1:0];
                           tx_valid_q <= 1'b1;
                           state_q    <= S_TX;
                        end
                        8'h05: begin
                           addr_q     <= pay_d[31:0];
                           tx_valid_q <= 1'b1;
                           state_q    <= S_TX;
                        end
                        8'h08: begin
                           wdata_q   <= pay_d[DW-1:0];
                           ax_addr_q <= addr_q;
                           awvalid_q <= 1'b1;
                           wvalid_q  <= 1'b1;
                           state_q   <= S_AXI_AWW;
                        end
                        default: begin
                           rx_ready_q <= 1'b1;
                           state_q    <= S_IDLE;
                        end
                     endcase
                  end
               end else if (timer_q == TW'(RX_TIMEOUT - 1)) begin
                  // payload stalled: drop what was staged, leave gpo/addr alone
                  rx_ready_q <= 1'b0;
                  tx_q       <= '0;
                  tx_q[TXW-1 -: 8] <= 8'hE1;
                  len_q      <= LW'(1);
                  tx_valid_q <= 1'b1;
                  state_q    <= S_TX;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end

            S_AXI_AR: begin
               if (m_axi_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= S_AXI_R;
               end
            end

            S_AXI_R: begin
               if (m_axi_rvalid) begin
                  rready_q <= 1'b0;
                  tx_q     <= '0;
                  tx_q[TXW-1 -: DW+8] <= {6'b0, m_axi_rresp, m_axi_rdata};
                  len_q      <= LW'(DATA_BYTES + 1);
                  addr_q     <= addr_q + 32'(DATA_BYTES);
                  tx_valid_q <= 1'b1;
                  state_q    <= S_TX;
               end
            end

            S_AXI_AWW: begin
               // AW and W complete independently; move on once both are taken
               if (m_axi_awready) awvalid_q <= 1'b0;
               if (m_axi_wready)  wvalid_q  <= 1'b0;
               if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                  bready_q <= 1'b1;
                  state_q  <= S_AXI_B;
               end
            end

            S_AXI_B: begin
               if (m_axi_bvalid) begin
                  bready_q <= 1'b0;
                  tx_q     <= '0;
                  tx_q[TXW-1 -: 8] <= {6'b0, m_axi_bresp};
                  len_q      <= LW'(1);
                  addr_q     <= addr_q + 32'(DATA_BYTES);
                  tx_valid_q <= 1'b1;
                  state_q    <= S_TX;
               end
            end

            S_TX: begin
               if (tx_ready) begin
                  len_q <= len_q - 1'b1;
                  if (len_q == LW'(1)) begin
                     tx_valid_q <= 1'b0;
                     rx_ready_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end else begin
                     tx_q <= {tx_q[TXW-9:0], 8'h00};
                  end
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign rx_ready      = rx_ready_q;
   assign tx_valid      = tx_valid_q;
   assign tx_data       = tx_q[TXW-1 -: 8];
   assign gpo           = gpo_q;
   assign m_axi_araddr  = ax_addr_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_arsize  = 3'($clog2(DATA_BYTES));
   assign m_axi_rready  = rready_q;
   assign m_axi_awaddr  = ax_addr_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awsize  = 3'($clog2(DATA_BYTES));
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = '1;
   assign m_axi_wlast   = 1'b1;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;

   // rlast carries no information for single-beat reads; the top shadow
   // byte is always shifted out before a payload completes
   logic unused_ok;
   assign unused_ok = &{1'b0, m_axi_rlast, pay_q[SHW-1 -: 8]};

endmodule

// File: tb/tb_uartprobe_engine.sv
// ---------------------------------------------------------------------------
// tb_uartprobe_engine
// Directed plus randomized command sequences against uartprobe_engine, with
// the bench acting as UART wrapper and AXI slave. Expected replies come from
// a small value model (gpo, address) following the protocol rules.
// ---------------------------------------------------------------------------
module tb_uartprobe_engine;

   localparam int          GB       = 4;
   localparam int          DB       = 1;
   localparam logic [31:0] GPO_RST  = 32'h1234_5678;
   localparam logic [31:0] ADDR_RST = 32'h0000_0000;
   localparam int          TO       = 32;
   localparam int          LIM      = 400;

   logic        clk = 1'b0;
   logic        aresetn;
   logic        rx_valid, rx_ready, tx_valid, tx_ready;
   logic [7:0]  rx_data, tx_data;
   logic [31:0] gpo, gpi;
   logic [31:0] m_axi_araddr, m_axi_awaddr;
   logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
   logic [2:0]  m_axi_arsize, m_axi_awsize;
   logic [7:0]  m_axi_rdata, m_axi_wdata;
   logic [1:0]  m_axi_rresp, m_axi_bresp;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic [0:0]  m_axi_wstrb;
   logic        m_axi_bvalid, m_axi_bready;

   int total = 0;
   int bad   = 0;
   logic [31:0] gpo_m, addr_m;
   int          gpo_changes = 0;
   logic [31:0] gpo_prev;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (gpo !== gpo_prev) gpo_changes <= gpo_changes + 1;
      gpo_prev <= gpo;
   end

   uartprobe_engine #(
      .GPIO_BYTES(GB), .DATA_BYTES(DB), .GPO_ON_RESET(GPO_RST),
      .AXI_ADDR_ON_RESET(ADDR_RST), .RX_TIMEOUT(TO)
   ) dut (
      .clk(clk), .aresetn(aresetn),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .gpo(gpo), .gpi(gpi),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready), .m_axi_arsize(m_axi_arsize),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready), .m_axi_rlast(m_axi_rlast),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready), .m_axi_awsize(m_axi_awsize),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (rx_ready !== 1'b1 && n < LIM) begin tick(); n++; end
      chk("rx_accept_timeout", 64'(n >= LIM), 64'(0));
      if (n < LIM) tick();
      rx_valid = 1'b0;
      $display("tx->dut byte %02h", b);
   endtask

   task automatic recv_byte(output logic [7:0] b);
      int n = 0;
      tx_ready = 1'b1;
      while (tx_valid !== 1'b1 && n < LIM) begin tick(); n++; end
      chk("tx_valid_timeout", 64'(n >= LIM), 64'(0));
      b = tx_data;
      tick();
      tx_ready = 1'b0;
      $display("dut->tb byte %02h", b);
   endtask

   task automatic expect_resp(input string tag, input int n, input logic [63:0] val);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         recv_byte(b);
         chk($sformatf("%s[%0d]", tag, i), 64'(b), 64'(val[8*(n-1-i) +: 8]));
      end
   endtask

   task automatic send_pay(input logic [7:0] op, input int n, input logic [31:0] val);
      send_byte(op);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         send_byte(val[8*(n-1-i) +: 8]);
      end
   endtask

   task automatic read_slave(input logic [31:0] exp_addr, input logic [7:0] d,
                             input logic [1:0] resp, input int stall);
      int n = 0;
      while (m_axi_arvalid !== 1'b1 && n < LIM) begin tick(); n++; end
      chk("arvalid_timeout", 64'(n >= LIM), 64'(0));
      chk("araddr", 64'(m_axi_araddr), 64'(exp_addr));
      chk("arsize", 64'(m_axi_arsize), 64'(0));
      m_axi_arready = 1'b1;
      tick();
      m_axi_arready = 1'b0;
      repeat (stall) tick();
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = d;
      m_axi_rresp  = resp;
      m_axi_rlast  = 1'($urandom);
      n = 0;
      while (m_axi_rready !== 1'b1 && n < LIM) begin tick(); n++; end
      chk("rready_timeout", 64'(n >= LIM), 64'(0));
      tick();
      m_axi_rvalid = 1'b0;
   endtask

   task automatic write_slave(input logic [31:0] exp_addr, input logic [7:0] exp_d,
                              input logic [1:0] resp, input int aw_d, input int w_d);
      int n = 0;
      int m = (aw_d > w_d) ? aw_d : w_d;
      while (!(m_axi_awvalid === 1'b1 && m_axi_wvalid === 1'b1) && n < LIM) begin tick(); n++; end
      chk("awwvalid_timeout", 64'(n >= LIM), 64'(0));
      chk("awaddr", 64'(m_axi_awaddr), 64'(exp_addr));
      chk("wdata", 64'(m_axi_wdata), 64'(exp_d));
      chk("wstrb_wlast_awsize", 64'({m_axi_wstrb, m_axi_wlast, m_axi_awsize}), 64'(5'b11000));
      for (int c = 0; c <= m; c++) begin
         m_axi_awready = (c == aw_d);
         m_axi_wready  = (c == w_d);
         tick();
      end
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      chk("aw_w_dropped", 64'({m_axi_awvalid, m_axi_wvalid}), 64'(0));
      n = 0;
      while (m_axi_bready !== 1'b1 && n < LIM) begin tick(); n++; end
      chk("bready_timeout", 64'(n >= LIM), 64'(0));
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = resp;
      tick();
      m_axi_bvalid = 1'b0;
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_gpo"}, 64'(gpo), 64'(GPO_RST));
      chk({tag, "_tx"}, 64'({tx_valid, tx_data}), 64'(0));
      chk({tag, "_readies"}, 64'({rx_ready, m_axi_rready, m_axi_bready}), 64'(0));
      chk({tag, "_valids"}, 64'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}), 64'(0));
   endtask

   task automatic do_reset(input string tag);
      aresetn = 1'b0;
      #2;
      check_reset_outs(tag);
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0;
      m_axi_wready = 0; m_axi_bvalid = 0; rx_valid = 0; tx_ready = 0;
      repeat (3) tick();
      check_reset_outs({tag, "_held"});
      aresetn = 1'b1;
      gpo_m  = GPO_RST;
      addr_m = ADDR_RST;
      $display("reset %s", tag);
   endtask

   initial begin : main
      logic [31:0] v;
      logic [7:0]  d, op;
      logic [1:0]  rs;
      int          c0, n, r;

      aresetn = 1'b0; rx_valid = 0; rx_data = 0; tx_ready = 0; gpi = 0;
      m_axi_arready = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rvalid = 0;
      m_axi_rlast = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = 0;
      m_axi_bvalid = 0;
      tick();
      do_reset("por");

      // GPO read of reset value
      send_byte(8'h03);
      expect_resp("gpo_rd_reset", 4, 64'(GPO_RST));

      // GPO write: applied atomically after the final payload byte
      c0 = gpo_changes;
      send_byte(8'h04); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
      tick();
      chk("gpo_before_last", 64'(gpo), 64'(GPO_RST));
      send_byte(8'hEF);
      expect_resp("gpo_wr_ack", 1, 64'(0));
      gpo_m = 32'hDEAD_BEEF;
      chk("gpo_after_wr", 64'(gpo), 64'(gpo_m));
      chk("gpo_change_count", 64'(gpo_changes - c0), 64'(1));

      // GPI read stays coherent while gpi toggles
      gpi = 32'hA1B2_C3D4;
      send_byte(8'h02);
      for (int i = 0; i < 4; i++) begin
         gpi = $urandom;
         recv_byte(d);
         chk($sformatf("gpi_coherent[%0d]", i), 64'(d), 64'(8'(32'hA1B2_C3D4 >> (8*(3-i)))));
      end

      // address wrap on AXI write at FFFFFFFF
      send_pay(8'h05, 4, 32'hFFFF_FFFF);
      expect_resp("addr_wr_ack", 1, 64'(0));
      send_pay(8'h08, 1, 32'h5A);
      write_slave(32'hFFFF_FFFF, 8'h5A, 2'd0, 3, 0);
      expect_resp("axi_wr_resp", 1, 64'(0));
      send_byte(8'h06);
      expect_resp("addr_wrapped", 4, 64'(0));

      // AXI read with slave stall and error response
      send_pay(8'h05, 4, 32'h0000_0100);
      expect_resp("addr_wr_ack2", 1, 64'(0));
      send_byte(8'h07);
      read_slave(32'h100, 8'h3C, 2'd2, 5);
      expect_resp("axi_rd", 2, 64'(16'h023C));
      send_byte(8'h06);
      expect_resp("addr_after_rd", 4, 64'(32'h101));
      addr_m = 32'h101;

      // payload timeout: E1, gpo untouched
      send_byte(8'h04); send_byte(8'h11);
      repeat (TO - 2) tick();
      chk("no_reply_before_timeout", 64'(tx_valid), 64'(0));
      expect_resp("timeout", 1, 64'(8'hE1));
      chk("gpo_after_timeout", 64'(gpo), 64'(gpo_m));

      // bad opcode with tx back-pressure
      send_byte(8'h7F);
      n = 0;
      while (tx_valid !== 1'b1 && n < LIM) begin tick(); n++; end
      chk("bad_op_valid_timeout", 64'(n >= LIM), 64'(0));
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("tx_stall_stable[%0d]", i), 64'({tx_valid, tx_data}), 64'(9'h1E0));
      end
      expect_resp("bad_op", 1, 64'(8'hE0));

      // randomized command mix against the value model
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 8);
         case (r)
            0: begin send_byte(8'h01); expect_resp("r_ping", 1, 64'(8'hA5)); end
            1: begin
               v = $urandom;
               send_pay(8'h04, 4, v);
               expect_resp("r_gpo_wr", 1, 64'(0));
               gpo_m = v;
               chk("r_gpo_pins", 64'(gpo), 64'(gpo_m));
            end
            2: begin send_byte(8'h03); expect_resp("r_gpo_rd", 4, 64'(gpo_m)); end
            3: begin
               v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
               send_pay(8'h05, 4, v);
               expect_resp("r_addr_wr", 1, 64'(0));
               addr_m = v;
            end
            4: begin send_byte(8'h06); expect_resp("r_addr_rd", 4, 64'(addr_m)); end
            5: begin
               d = 8'($urandom); rs = 2'($urandom);
               send_byte(8'h07);
               read_slave(addr_m, d, rs, $urandom_range(0, 4));
               expect_resp("r_axi_rd", 2, 64'({6'b0, rs, d}));
               addr_m = addr_m + 32'(DB);
            end
            6: begin
               d = 8'($urandom); rs = 2'($urandom);
               send_pay(8'h08, 1, 32'(d));
               write_slave(addr_m, d, rs, $urandom_range(0, 3), $urandom_range(0, 3));
               expect_resp("r_axi_wr", 1, 64'({6'b0, rs}));
               addr_m = addr_m + 32'(DB);
            end
            7: begin
               op = 8'($urandom_range(9, 255));
               send_byte(op);
               expect_resp("r_bad_op", 1, 64'(8'hE0));
            end
            default: begin
               v = $urandom; gpi = v;
               send_byte(8'h02);
               gpi = ~v;
               expect_resp("r_gpi_rd", 4, 64'(v));
            end
         endcase
      end

      // reset while waiting for read data
      send_pay(8'h05, 4, 32'h0000_0200);
      expect_resp("pre_rst_addr", 1, 64'(0));
      send_byte(8'h07);
      n = 0;
      while (m_axi_arvalid !== 1'b1 && n < LIM) begin tick(); n++; end
      m_axi_arready = 1'b1; tick(); m_axi_arready = 1'b0;
      tick();
      chk("in_axi_r", 64'(m_axi_rready), 64'(1));
      do_reset("mid_axi_r");
      send_byte(8'h01);
      expect_resp("ping_after_rst1", 1, 64'(8'hA5));
      send_byte(8'h06);
      expect_resp("addr_after_rst", 4, 64'(ADDR_RST));

      // reset while a reply is pending
      send_byte(8'h03);
      n = 0;
      while (tx_valid !== 1'b1 && n < LIM) begin tick(); n++; end
      chk("in_tx", 64'(tx_valid), 64'(1));
      do_reset("mid_tx");
      send_byte(8'h01);
      expect_resp("ping_after_rst2", 1, 64'(8'hA5));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #900_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
